// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the fetch PC, issues single-outstanding word requests,
// buffers responses in a small prefetch FIFO and handles execute redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        instrValid,
  output logic [31:0] instruction,
  output logic [31:0] instrPC,
  input  logic        instrReady
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0]     pc_mem_q   [FIFO_DEPTH];
  logic [31:0]     data_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            pending_q, pending_d;
  logic            stale_q, stale_d;
  logic            ack, push, pop;
  logic [31:0]     target;
  logic            unused_bits;

  assign ack         = imemAck & pending_q;
  assign push        = ack & ~stale_q & ~redirect;
  assign pop         = instrValid & instrReady & ~redirect;
  assign target      = {redirectPC[31:2], 2'b00};
  assign unused_bits = ^redirectPC[1:0];

  assign imemReq     = pending_q;
  assign imemAddr    = addr_q;
  assign instrValid  = (count_q != '0);
  assign instruction = data_mem_q[rd_ptr_q];
  assign instrPC     = pc_mem_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    stale_d    = stale_q;
    pending_d  = pending_q;
    addr_d     = addr_q;

    if (redirect) begin
      count_d    = '0;
      fetch_pc_d = target;
    end else begin
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (push) fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // An unacked request keeps its address; a redirect only marks its response for discard.
    if (pending_q && !ack) begin
      if (redirect) stale_d = 1'b1;
    end else begin
      stale_d   = 1'b0;
      pending_d = redirect || (count_d < DepthCnt);
      addr_d    = fetch_pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      pending_q  <= 1'b0;
      stale_q    <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        pc_mem_q[i]   <= RESET_PC;
        data_mem_q[i] <= Nop;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      pending_q  <= pending_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
          data_mem_q[wr_ptr_q] <= imemData;
          wr_ptr_q             <= wr_ptr_q + PtrW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model answers requests, expected {pc, word} pairs
// are queued per scenario and compared as the decoder side consumes them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPC = 32'h0;
  logic        instrValid;
  logic [31:0] instruction;
  logic [31:0] instrPC;
  logic        instrReady = 1'b0;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .redirect(redirect), .redirectPC(redirectPC),
    .instrValid(instrValid), .instruction(instruction), .instrPC(instrPC),
    .instrReady(instrReady)
  );

  // Zero-wait memory returning ~addr, decoder always ready; used for the wrap-around case.
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
    .clk(clk), .reset(reset),
    .imemReq(w_req), .imemAddr(w_addr), .imemAck(w_req), .imemData(~w_addr),
    .redirect(1'b0), .redirectPC(32'h0),
    .instrValid(w_valid), .instruction(w_instr), .instrPC(w_pc),
    .instrReady(1'b1)
  );

  int          errors   = 0;
  int          checks   = 0;
  int          consumed = 0;
  int          lat      = 0;
  int          wait_n   = 0;
  logic        rdy      = 1'b0;
  logic        held     = 1'b0;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] key      = 32'h0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, imemReq, 1'b0);
    chk({tag, "_addr"}, imemAddr, 32'h0);
    chk({tag, "_valid"}, instrValid, 1'b0);
    chk({tag, "_instr"}, instruction, 32'h0000_0013);
    chk({tag, "_pc"}, instrPC, 32'h0);
  endtask

  // Called just after a falling edge: memory response, decoder handshake, scoreboard pop.
  task automatic drive(input logic redir, input logic [31:0] tgt);
    if (imemReq) begin
      if (held) chk("hold_addr", imemAddr, held_addr);
      if (wait_n >= lat) begin
        imemAck  = 1'b1;
        imemData = imemAddr ^ key;
        held     = 1'b0;
        wait_n   = 0;
      end else begin
        imemAck   = 1'b0;
        wait_n++;
        held      = 1'b1;
        held_addr = imemAddr;
      end
    end else begin
      imemAck = 1'b0;
      held    = 1'b0;
      wait_n  = 0;
    end
    redirect   = redir;
    redirectPC = tgt;
    instrReady = rdy;
    if (instrValid && rdy && !redir) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL stream_extra: observed pc %h expected no delivery", instrPC);
      end
      if (exp_q.size() > 0) chk("stream", {instrPC, instruction}, exp_q.pop_front());
      consumed++;
    end
    if (redir) exp_q.delete();
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b0, 32'h0);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back({pc, pc ^ key});
    end
  endtask

  // Leaves the bench at a falling edge with reset asserted; caller releases it.
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    imemAck    = 1'b0;
    redirect   = 1'b0;
    instrReady = 1'b0;
    rdy        = 1'b0;
    held       = 1'b0;
    wait_n     = 0;
    consumed   = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_req(input logic [31:0] a, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (imemReq && imemAddr == a) begin
        found = 1'b1;
        break;
      end
      drive(1'b0, 32'h0);
    end
    chk(tag, found, 1'b1);
  endtask

  initial begin
    logic [31:0] e;

    reset = 1'b1;
    #1 reset = 1'b0;
    #1 chk_reset_vals("por");

    // Reset release and zero-wait streaming, plus wrap-around on the second instance.
    lat = 0; key = 32'h0; rdy = 1'b1;
    push_stream(32'h0, 12);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("first_req", imemReq, 1'b1);
        chk("first_addr", imemAddr, 32'h0);
        chk("first_not_valid", instrValid, 1'b0);
      end
      if (c == 2) chk("first_valid", instrValid, 1'b1);
      if (c <= 3) begin
        e = 32'hFFFF_FFF8 + 32'(4 * (c - 1));
        chk("wrap_addr", w_addr, e);
      end
      if (c >= 2 && c <= 4) begin
        e = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
        chk("wrap_head", {w_valid, w_pc, w_instr}, {1'b1, e, ~e});
      end
      drive(1'b0, 32'h0);
    end
    chk("stream_rate", consumed, 7);

    // Backpressure fills the FIFO, then release drains in order.
    do_reset();
    lat = 0; key = 32'h1234_0000; rdy = 1'b0;
    push_stream(32'h0, 10);
    reset = 1'b1;
    cyc(4);
    @(negedge clk);
    chk("full_req_off", imemReq, 1'b0);
    chk("full_head", {instrValid, instrPC, instruction}, {1'b1, 32'h0, key});
    drive(1'b0, 32'h0);
    rdy = 1'b1;
    @(negedge clk);
    chk("pop_cycle_req_off", imemReq, 1'b0);
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("refetch_req", {imemReq, imemAddr}, {1'b1, 32'h8});
    drive(1'b0, 32'h0);
    cyc(3);
    chk("drain_count", consumed, 5);

    // Asynchronous reset with the FIFO full, off the clock edge.
    rdy = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("full_before_reset", {imemReq, instrValid}, {1'b0, 1'b1});
    #2 reset = 1'b0;
    #1 chk_reset_vals("async");

    // Redirect while a slow fetch of 0x8 is outstanding.
    do_reset();
    lat = 3; key = 32'hAB00_0000; rdy = 1'b1;
    push_stream(32'h0, 2);
    reset = 1'b1;
    wait_req(32'h8, 40, "reach_fetch_8");
    drive(1'b0, 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h100);
    push_stream(32'h100, 8);
    @(negedge clk);
    chk("redir_flush", instrValid, 1'b0);
    chk("stale_hold", {imemReq, imemAddr}, {1'b1, 32'h8});
    drive(1'b0, 32'h0);
    wait_req(32'h100, 20, "redir_target_req");
    drive(1'b0, 32'h0);
    cyc(20);
    chk("redir_progress", consumed >= 4, 1'b1);

    // Redirect to a misaligned target in a cycle with both an ack and a pop.
    do_reset();
    lat = 0; key = 32'h5A00_0000; rdy = 1'b1;
    push_stream(32'h0, 10);
    reset = 1'b1;
    cyc(4);
    @(negedge clk);
    chk("ack_pop_setup", {imemReq, instrValid}, {1'b1, 1'b1});
    drive(1'b1, 32'h203);
    push_stream(32'h200, 10);
    @(negedge clk);
    chk("redir2_flush", instrValid, 1'b0);
    chk("redir2_addr", {imemReq, imemAddr}, {1'b1, 32'h200});
    drive(1'b0, 32'h0);
    cyc(3);
    chk("redir2_count", consumed, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
